// File: rtl/bp_nonsynth_host_mux.sv
// Merge stage in front of the nonsynth host: round-robin arbitration of
// single-beat I/O commands from several requesters onto one host command
// port, with an in-order tag queue that steers each host response back to
// the requester that issued the matching command.
module bp_nonsynth_host_mux
    #(parameter int paddr_width_p          = 40
    , parameter int lce_id_width_p         = 4
    , parameter int lce_assoc_p            = 8
    , parameter int io_data_width_p        = 64
    , parameter int num_req_p              = 2
    , parameter int host_max_outstanding_p = 32
    , localparam int lg_req_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1
    , localparam int io_mem_msg_header_width_lp =
          4 + 4 + paddr_width_p + 3 + lce_id_width_p + $clog2(lce_assoc_p) + 3
    , localparam int ptr_width_lp =
          (host_max_outstanding_p > 1) ? $clog2(host_max_outstanding_p) : 1
    , localparam int out_width_lp = $clog2(host_max_outstanding_p + 1)
    )
    (input  logic                                                   clk_i
    , input  logic                                                  reset_i

    , input  logic [num_req_p-1:0][io_mem_msg_header_width_lp-1:0] req_cmd_header_i
    , input  logic [num_req_p-1:0][io_data_width_p-1:0]            req_cmd_data_i
    , input  logic [num_req_p-1:0]                                  req_cmd_v_i
    , input  logic [num_req_p-1:0]                                  req_cmd_last_i
    , output logic [num_req_p-1:0]                                  req_cmd_ready_and_o

    , output logic [num_req_p-1:0][io_mem_msg_header_width_lp-1:0] req_resp_header_o
    , output logic [num_req_p-1:0][io_data_width_p-1:0]            req_resp_data_o
    , output logic [num_req_p-1:0]                                  req_resp_v_o
    , output logic [num_req_p-1:0]                                  req_resp_last_o
    , input  logic [num_req_p-1:0]                                  req_resp_ready_and_i

    , output logic [io_mem_msg_header_width_lp-1:0]                 mem_cmd_header_o
    , output logic [io_data_width_p-1:0]                            mem_cmd_data_o
    , output logic                                                  mem_cmd_v_o
    , output logic                                                  mem_cmd_last_o
    , input  logic                                                  mem_cmd_ready_and_i

    , input  logic [io_mem_msg_header_width_lp-1:0]                 mem_resp_header_i
    , input  logic [io_data_width_p-1:0]                            mem_resp_data_i
    , input  logic                                                  mem_resp_v_i
    , input  logic                                                  mem_resp_last_i
    , output logic                                                  mem_resp_ready_and_o

    , output logic [out_width_lp-1:0]                               outstanding_o
    );

    typedef enum logic {e_idle, e_lock} state_e;

    state_e                 state_q, state_d;
    logic [lg_req_lp-1:0]   rr_q, rr_d;
    logic [lg_req_lp-1:0]   gnt_q, gnt_d;

    logic [lg_req_lp-1:0]   tag_mem [host_max_outstanding_p];
    logic [ptr_width_lp-1:0] wptr_q, rptr_q;
    logic [out_width_lp-1:0] count_q;

    logic                   full, empty;
    logic [lg_req_lp-1:0]   rr_winner;
    logic [lg_req_lp-1:0]   gnt_idx;
    logic [lg_req_lp-1:0]   head_id;
    logic [num_req_p-1:0]   gnt_oh;
    logic                   cmd_hs, resp_hs;

    function automatic logic [lg_req_lp-1:0] req_inc(input logic [lg_req_lp-1:0] x);
        return (x == lg_req_lp'(num_req_p - 1)) ? '0 : x + lg_req_lp'(1);
    endfunction

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(host_max_outstanding_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    // Full/empty come straight from the registered count, so a same-cycle pop
    // never opens the command path.
    assign full    = (count_q == out_width_lp'(host_max_outstanding_p));
    assign empty   = (count_q == '0);
    assign head_id = tag_mem[rptr_q];

    // Round-robin search: first valid requester at or after rr_q, wrapping.
    always_comb begin
        logic found;
        found     = 1'b0;
        rr_winner = rr_q;
        for (int k = 0; k < num_req_p; k++) begin
            int idx;
            idx = (int'(rr_q) + k) % num_req_p;
            if (!found && req_cmd_v_i[idx]) begin
                found     = 1'b1;
                rr_winner = lg_req_lp'(idx);
            end
        end
    end

    // A stalled offer keeps its grant so the host sees a stable header.
    assign gnt_idx = (state_q == e_lock) ? gnt_q : rr_winner;

    assign mem_cmd_header_o = req_cmd_header_i[gnt_idx];
    assign mem_cmd_data_o   = req_cmd_data_i[gnt_idx];
    assign mem_cmd_last_o   = req_cmd_last_i[gnt_idx];
    assign mem_cmd_v_o      = ~reset_i & ~full & req_cmd_v_i[gnt_idx];

    assign mem_resp_ready_and_o = ~reset_i & ~empty & req_resp_ready_and_i[head_id];

    assign cmd_hs  = mem_cmd_v_o & mem_cmd_ready_and_i;
    assign resp_hs = mem_resp_v_i & mem_resp_ready_and_o;

    assign outstanding_o = count_q;

    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_req
        assign gnt_oh[gi]              = req_cmd_v_i[gi] & (gnt_idx == lg_req_lp'(gi));
        assign req_cmd_ready_and_o[gi] = ~reset_i & gnt_oh[gi] & mem_cmd_ready_and_i & ~full;
        assign req_resp_header_o[gi]   = mem_resp_header_i;
        assign req_resp_data_o[gi]     = mem_resp_data_i;
        assign req_resp_last_o[gi]     = mem_resp_last_i;
        assign req_resp_v_o[gi]        = ~reset_i & mem_resp_v_i & ~empty
                                       & (head_id == lg_req_lp'(gi));
    end

    // Arbiter next state: lock on a refused offer, rotate priority on handshake.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        case (state_q)
            e_idle: begin
                if (cmd_hs) begin
                    rr_d = req_inc(rr_winner);
                end else if (mem_cmd_v_o) begin
                    state_d = e_lock;
                    gnt_d   = rr_winner;
                end
            end
            e_lock: begin
                if (cmd_hs) begin
                    state_d = e_idle;
                    rr_d    = req_inc(gnt_q);
                end
            end
            default: state_d = e_idle;
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_idle;
            rr_q    <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
        end
    end

    // Tag queue pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (cmd_hs)
                wptr_q <= ptr_inc(wptr_q);
            if (resp_hs)
                rptr_q <= ptr_inc(rptr_q);
            if (cmd_hs && !resp_hs)
                count_q <= count_q + out_width_lp'(1);
            else if (!cmd_hs && resp_hs)
                count_q <= count_q - out_width_lp'(1);
        end
    end

    // Tag storage: record the issuing requester at the command handshake.
    always_ff @(posedge clk_i) begin
        if (cmd_hs)
            tag_mem[wptr_q] <= gnt_idx;
    end

    // Protocol checks for traffic this stage cannot handle.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (mem_resp_v_i && empty)
                $error("host_mux: response valid with no command outstanding");
            if (cmd_hs && !mem_cmd_last_o)
                $error("host_mux: multi-beat command is unsupported");
            if (resp_hs && !mem_resp_last_i)
                $error("host_mux: multi-beat response is unsupported");
        end
    end

endmodule

// File: tb/tb_bp_nonsynth_host_mux.sv
// Bench for bp_nonsynth_host_mux: requesters and host are modelled as
// transaction queues; expected mux outputs are derived every cycle from
// round-robin fairness, held offers and in-order response return.
module tb_bp_nonsynth_host_mux;
    localparam int N      = 2;
    localparam int DEPTH  = 32;
    localparam int PADDR  = 40;
    localparam int LCE_ID = 4;
    localparam int ASSOC  = 8;
    localparam int HDR_W  = 4 + 4 + PADDR + 3 + LCE_ID + $clog2(ASSOC) + 3;
    localparam int DW     = 64;
    localparam int OW     = $clog2(DEPTH + 1);
    localparam logic [HDR_W-1:0] PUTCHAR_HDR = HDR_W'(64'h0011_0010_0000_1000);

    logic clk = 1'b0;
    logic reset_i;
    logic [N-1:0][HDR_W-1:0] req_cmd_header_i;
    logic [N-1:0][DW-1:0]    req_cmd_data_i;
    logic [N-1:0]            req_cmd_v_i, req_cmd_last_i, req_cmd_ready_and_o;
    logic [N-1:0][HDR_W-1:0] req_resp_header_o;
    logic [N-1:0][DW-1:0]    req_resp_data_o;
    logic [N-1:0]            req_resp_v_o, req_resp_last_o, req_resp_ready_and_i;
    logic [HDR_W-1:0]        mem_cmd_header_o, mem_resp_header_i;
    logic [DW-1:0]           mem_cmd_data_o, mem_resp_data_i;
    logic                    mem_cmd_v_o, mem_cmd_last_o, mem_cmd_ready_and_i;
    logic                    mem_resp_v_i, mem_resp_last_i, mem_resp_ready_and_o;
    logic [OW-1:0]           outstanding_o;

    bp_nonsynth_host_mux #(
        .paddr_width_p(PADDR), .lce_id_width_p(LCE_ID), .lce_assoc_p(ASSOC),
        .io_data_width_p(DW), .num_req_p(N), .host_max_outstanding_p(DEPTH)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_cmd_header_i(req_cmd_header_i), .req_cmd_data_i(req_cmd_data_i),
        .req_cmd_v_i(req_cmd_v_i), .req_cmd_last_i(req_cmd_last_i),
        .req_cmd_ready_and_o(req_cmd_ready_and_o),
        .req_resp_header_o(req_resp_header_o), .req_resp_data_o(req_resp_data_o),
        .req_resp_v_o(req_resp_v_o), .req_resp_last_o(req_resp_last_o),
        .req_resp_ready_and_i(req_resp_ready_and_i),
        .mem_cmd_header_o(mem_cmd_header_o), .mem_cmd_data_o(mem_cmd_data_o),
        .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_last_o(mem_cmd_last_o),
        .mem_cmd_ready_and_i(mem_cmd_ready_and_i),
        .mem_resp_header_i(mem_resp_header_i), .mem_resp_data_i(mem_resp_data_i),
        .mem_resp_v_i(mem_resp_v_i), .mem_resp_last_i(mem_resp_last_i),
        .mem_resp_ready_and_o(mem_resp_ready_and_o),
        .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [HDR_W-1:0] hdr;
        logic [DW-1:0]    data;
        int               cyc;
    } host_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Requester side: each requester holds one offer until it is taken.
    logic             has_cmd  [N];
    logic [HDR_W-1:0] cmd_hdr  [N];
    logic [DW-1:0]    cmd_data [N];
    logic [DW-1:0]    exp_resp [N][$];
    int               resp_cnt [N];

    // Host side and ordering model.
    int    tagq[$];
    host_t hostq[$];
    int    grant_log[$];
    int    next_pri = 0;
    int    presented = -1;

    // Traffic knobs.
    int          spawn_mask = 0;
    int          spawn_prob = 0;
    int          host_cmd_prob = 100;
    int          host_resp_prob = 100;
    int          resp_rdy_prob = 100;
    logic [N-1:0] resp_rdy_mask = '1;

    // Per-cycle observations for directed checks.
    logic [N-1:0] snap_cmd_rdy, snap_rv;
    logic         snap_mrr, snap_push, snap_pop;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic busy();
        logic b;
        b = (tagq.size() != 0);
        for (int i = 0; i < N; i++)
            if (has_cmd[i]) b = 1'b1;
        return b;
    endfunction

    task automatic set_cmd(input int i);
        has_cmd[i]  = 1'b1;
        cmd_hdr[i]  = HDR_W'({$urandom, $urandom});
        cmd_data[i] = {$urandom, $urandom};
    endtask

    task automatic clear_model();
        tagq.delete();
        hostq.delete();
        for (int i = 0; i < N; i++) begin
            exp_resp[i].delete();
            has_cmd[i] = 1'b0;
        end
        presented = -1;
        next_pri  = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!has_cmd[i] && spawn_mask[i] && $urandom_range(99) < spawn_prob)
                set_cmd(i);
            req_cmd_v_i[i]          = has_cmd[i];
            req_cmd_header_i[i]     = cmd_hdr[i];
            req_cmd_data_i[i]       = cmd_data[i];
            req_cmd_last_i[i]       = 1'b1;
            req_resp_ready_and_i[i] = resp_rdy_mask[i] && ($urandom_range(99) < resp_rdy_prob);
        end
        mem_cmd_ready_and_i = ($urandom_range(99) < host_cmd_prob);
        if (hostq.size() > 0 && hostq[0].cyc < cyc && $urandom_range(99) < host_resp_prob) begin
            mem_resp_v_i      = 1'b1;
            mem_resp_header_i = ~hostq[0].hdr;
            mem_resp_data_i   = hostq[0].data + 64'd1;
        end else begin
            mem_resp_v_i      = 1'b0;
            mem_resp_header_i = HDR_W'({$urandom, $urandom});
            mem_resp_data_i   = {$urandom, $urandom};
        end
        mem_resp_last_i = 1'b1;
    endtask

    // Compare every DUT output with what the transaction model requires,
    // then advance the model by the handshakes of this cycle.
    task automatic check_cycle();
        int g;
        int id;
        logic full, empty, exp_v, exp_mrr, push, pop;
        logic [N-1:0] exp_rdy, exp_rv;
        logic [DW-1:0] exp_d;
        host_t h;

        full  = (tagq.size() == DEPTH);
        empty = (tagq.size() == 0);
        g = -1;
        if (presented >= 0) begin
            g = presented;
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (next_pri + k) % N;
                if (g < 0 && req_cmd_v_i[idx]) g = idx;
            end
        end
        exp_v   = (g >= 0) && !full;
        exp_rdy = '0;
        if (g >= 0 && mem_cmd_ready_and_i && !full) exp_rdy[g] = 1'b1;
        exp_rv  = '0;
        exp_mrr = 1'b0;
        if (!empty) begin
            exp_mrr = req_resp_ready_and_i[tagq[0]];
            if (mem_resp_v_i) exp_rv[tagq[0]] = 1'b1;
        end

        chk("mem_cmd_v", 128'(mem_cmd_v_o), 128'(exp_v));
        chk("req_cmd_ready", 128'(req_cmd_ready_and_o), 128'(exp_rdy));
        if (exp_v) begin
            chk("mem_cmd_header", 128'(mem_cmd_header_o), 128'(cmd_hdr[g]));
            chk("mem_cmd_data", 128'(mem_cmd_data_o), 128'(cmd_data[g]));
            chk("mem_cmd_last", 128'(mem_cmd_last_o), 128'(1));
        end
        chk("mem_resp_ready", 128'(mem_resp_ready_and_o), 128'(exp_mrr));
        chk("req_resp_v", 128'(req_resp_v_o), 128'(exp_rv));
        if (mem_resp_v_i) begin
            for (int i = 0; i < N; i++) begin
                chk("req_resp_header", 128'(req_resp_header_o[i]), 128'(mem_resp_header_i));
                chk("req_resp_last", 128'(req_resp_last_o[i]), 128'(1));
            end
        end
        chk("outstanding", 128'(outstanding_o), 128'(tagq.size()));

        push = exp_v && mem_cmd_ready_and_i;
        pop  = mem_resp_v_i && exp_mrr;
        snap_cmd_rdy = req_cmd_ready_and_o;
        snap_rv      = req_resp_v_o;
        snap_mrr     = mem_resp_ready_and_o;
        snap_push    = push;
        snap_pop     = pop;

        if (pop) begin
            id = tagq.pop_front();
            h  = hostq.pop_front();
            exp_d = (exp_resp[id].size() > 0) ? exp_resp[id].pop_front() : '0;
            chk("resp_data_to_issuer", 128'(req_resp_data_o[id]), 128'(exp_d));
            resp_cnt[id]++;
            $display("cyc %0d resp -> req%0d data=%h", cyc, id, req_resp_data_o[id]);
        end
        if (push) begin
            tagq.push_back(g);
            h.hdr = cmd_hdr[g]; h.data = cmd_data[g]; h.cyc = cyc;
            hostq.push_back(h);
            exp_resp[g].push_back(cmd_data[g] + 64'd1);
            grant_log.push_back(g);
            has_cmd[g] = 1'b0;
            next_pri   = (g + 1) % N;
            presented  = -1;
            if (cmd_hdr[g] == PUTCHAR_HDR)
                $display("cyc %0d cmd req%0d putchar '%c'", cyc, g, cmd_data[g][7:0]);
            else
                $display("cyc %0d cmd req%0d data=%h", cyc, g, cmd_data[g]);
        end else if (exp_v) begin
            presented = g;
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset_i              = 1'b1;
        req_cmd_v_i          = '1;
        req_cmd_last_i       = '1;
        req_resp_ready_and_i = '1;
        mem_cmd_ready_and_i  = 1'b1;
        mem_resp_v_i         = 1'b1;
        mem_resp_last_i      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mem_cmd_v", 128'(mem_cmd_v_o), 128'(0));
        chk("rst_req_cmd_ready", 128'(req_cmd_ready_and_o), 128'(0));
        chk("rst_req_resp_v", 128'(req_resp_v_o), 128'(0));
        chk("rst_mem_resp_ready", 128'(mem_resp_ready_and_o), 128'(0));
        chk("rst_outstanding", 128'(outstanding_o), 128'(0));
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        clear_model();
    endtask

    task automatic drain();
        spawn_mask = 0; host_cmd_prob = 100; host_resp_prob = 100;
        resp_rdy_prob = 100; resp_rdy_mask = '1;
        for (int t = 0; t < 200 && busy(); t++) cycle();
        checks++;
        if (busy()) begin
            errors++;
            $display("FAIL drain_timeout: outstanding %0d required 0", tagq.size());
        end
    endtask

    task automatic check_grants(input string name, input int n, input int exp0, input int exp1);
        for (int t = 0; t < 60 && grant_log.size() < n; t++) cycle();
        for (int k = 0; k < n; k++) begin
            if (k < grant_log.size())
                chk(name, 128'(grant_log[k]), 128'((k % 2 == 0) ? exp0 : exp1));
            else
                chk(name, 128'(-1), 128'((k % 2 == 0) ? exp0 : exp1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [HDR_W-1:0] hdr1;
        int r0, r1;
        req_cmd_header_i = '0; req_cmd_data_i = '0;
        mem_resp_header_i = '0; mem_resp_data_i = '0;
        for (int i = 0; i < N; i++) begin
            resp_cnt[i] = 0; has_cmd[i] = 1'b0; cmd_hdr[i] = '0; cmd_data[i] = '0;
        end
        do_reset();

        // Putchar 'A' from requester 0: outstanding 0 -> 1 -> 0.
        chk("putchar_out_before", 128'(outstanding_o), 128'(0));
        r0 = resp_cnt[0];
        has_cmd[0] = 1'b1; cmd_hdr[0] = PUTCHAR_HDR; cmd_data[0] = 64'h41;
        cycle();
        chk("putchar_out_accepted", 128'(outstanding_o), 128'(1));
        cycle();
        chk("putchar_out_answered", 128'(outstanding_o), 128'(0));
        chk("putchar_resp_count", 128'(resp_cnt[0]), 128'(r0 + 1));

        // Fairness: both requesters always valid, host always ready.
        do_reset();
        grant_log.delete();
        spawn_mask = 3; spawn_prob = 100;
        check_grants("fair_grant", 8, 0, 1);
        drain();

        // Stall with req1 granted; req0 arrives mid-stall and must wait.
        host_cmd_prob = 0;
        set_cmd(1);
        hdr1 = cmd_hdr[1];
        cycle();
        set_cmd(0);
        for (int t = 0; t < 4; t++) begin
            cycle();
            chk("stall_header_held", 128'(mem_cmd_header_o), 128'(hdr1));
        end
        grant_log.delete();
        host_cmd_prob = 100;
        check_grants("stall_grant", 2, 1, 0);
        drain();

        // Fill the tag queue with responses stalled.
        host_resp_prob = 0; spawn_mask = 3; spawn_prob = 100;
        for (int t = 0; t < 100 && tagq.size() < DEPTH; t++) cycle();
        chk("full_outstanding", 128'(outstanding_o), 128'(32));
        cycle();
        chk("full_no_ready", 128'(snap_cmd_rdy), 128'(0));
        host_resp_prob = 100;
        cycle();
        chk("full_pop_happened", 128'(snap_pop), 128'(1));
        chk("full_no_ready_on_pop", 128'(snap_cmd_rdy), 128'(0));
        host_resp_prob = 0;
        cycle();
        chk("full_accept_after_pop", 128'(snap_push), 128'(1));
        chk("full_outstanding_again", 128'(outstanding_o), 128'(32));
        drain();

        // In-order return: req1 then req0 outstanding, req1 not ready.
        host_resp_prob = 0;
        set_cmd(1);
        cycle();
        set_cmd(0);
        cycle();
        host_resp_prob = 100; resp_rdy_mask = 2'b01;
        for (int t = 0; t < 3; t++) begin
            cycle();
            chk("order_mem_resp_ready", 128'(snap_mrr), 128'(0));
            chk("order_resp_v_head", 128'(snap_rv), 128'(2'b10));
        end
        drain();

        // Reset with three commands outstanding.
        host_resp_prob = 0; spawn_mask = 1; spawn_prob = 100;
        for (int t = 0; t < 20 && tagq.size() < 3; t++) cycle();
        chk("mid_outstanding", 128'(outstanding_o), 128'(3));
        do_reset();
        grant_log.delete();
        set_cmd(0); set_cmd(1);
        check_grants("post_reset_grant", 2, 0, 1);
        drain();
        r1 = resp_cnt[1];
        set_cmd(1);
        drain();
        chk("post_reset_req1_resp", 128'(resp_cnt[1]), 128'(r1 + 1));

        // Randomized traffic.
        for (int blk = 0; blk < 10; blk++) begin
            spawn_mask     = 3;
            spawn_prob     = int'($urandom_range(100, 20));
            host_cmd_prob  = int'($urandom_range(100, 30));
            host_resp_prob = int'($urandom_range(100, 0));
            resp_rdy_prob  = int'($urandom_range(100, 30));
            resp_rdy_mask  = '1;
            for (int t = 0; t < 50; t++) cycle();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
